// File: rtl/wb_slave_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_M masters, granting per CYC.
// Grant one edge after request; owner steered combinationally; watchdog ERRs a stalled strobe.
module wb_slave_port_arbiter #(
   parameter int NUM_M      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_M-1:0]               m_cyc_i,
   input  logic [NUM_M-1:0]               m_stb_i,
   input  logic [NUM_M-1:0]               m_we_i,
   input  logic [NUM_M*DATA_WIDTH/8-1:0]  m_sel_i,
   input  logic [NUM_M*ADDR_WIDTH-1:0]    m_adr_i,
   input  logic [NUM_M*DATA_WIDTH-1:0]    m_dat_i,
   output logic [DATA_WIDTH-1:0]          m_dat_o,
   output logic [NUM_M-1:0]               m_ack_o,
   output logic [NUM_M-1:0]               m_err_o,
   output logic                           s_cyc_o,
   output logic                           s_stb_o,
   output logic                           s_we_o,
   output logic [DATA_WIDTH/8-1:0]        s_sel_o,
   output logic [ADDR_WIDTH-1:0]          s_adr_o,
   output logic [DATA_WIDTH-1:0]          s_dat_o,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   output logic [NUM_M-1:0]               gnt_o
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int SW = DATA_WIDTH / 8;
   localparam int IW = $clog2(NUM_M);
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, OWN} state_e;

   state_e           state_q, state_d;
   logic [NUM_M-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    last_q, last_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic [IW-1:0]    owner, pick;
   logic             owned, own_stb, wd_fire, found;

   always_comb begin
      owner = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (gnt_q[k]) owner = IW'(k);
      end
   end

   // First requester after the previous owner, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_M; i++) begin
         if (!found && m_cyc_i[(int'(last_q) + i) % NUM_M]) begin
            pick  = IW'((int'(last_q) + i) % NUM_M);
            found = 1'b1;
         end
      end
   end

   assign owned   = (state_q == OWN);
   assign own_stb = owned & m_stb_i[owner];
   assign wd_fire = (TIMEOUT != 0) && own_stb && !s_ack_i && (wd_q == WW'(TIMEOUT));
   assign gnt_o   = gnt_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (|m_cyc_i) begin
               state_d = OWN;
               gnt_d   = NUM_M'(1) << pick;
            end
         end
         OWN: begin
            if (!m_cyc_i[owner]) begin
               state_d = IDLE;
               gnt_d   = '0;
               last_d  = owner;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall counter only advances while the owner keeps an unanswered strobe.
   always_comb begin
      wd_d = '0;
      if ((TIMEOUT != 0) && owned && (state_d == OWN) && own_stb &&
          !s_ack_i && !s_err_i && !wd_fire)
         wd_d = wd_q + 1'b1;
   end

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_dat_o = '0;
      if (owned) begin
         s_cyc_o        = m_cyc_i[owner];
         s_stb_o        = m_stb_i[owner] & ~wd_fire;
         s_we_o         = m_we_i[owner];
         s_sel_o        = m_sel_i[int'(owner)*SW +: SW];
         s_adr_o        = m_adr_i[int'(owner)*AW +: AW];
         s_dat_o        = m_dat_i[int'(owner)*DW +: DW];
         m_ack_o[owner] = s_ack_i & own_stb;
         m_err_o[owner] = (s_err_i & own_stb) | wd_fire;
         m_dat_o        = s_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NUM_M - 1);
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end
endmodule

// File: tb/tb_wb_slave_port_arbiter.sv
// Directed bench for wb_slave_port_arbiter: reset, grant, round robin, wrap, watchdog, isolation.
module tb_wb_slave_port_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    m_cyc, m_stb, m_we;
   logic [N*DW/8-1:0] m_sel;
   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat;
   logic [DW-1:0]   s_dat_i;
   logic            s_ack, s_err;

   logic [DW-1:0]   m_dat_o, m_dat_o0;
   logic [N-1:0]    m_ack_o, m_err_o, gnt, m_ack_o0, m_err_o0, gnt0;
   logic            s_cyc_o, s_stb_o, s_we_o, s_cyc_o0, s_stb_o0, s_we_o0;
   logic [DW/8-1:0] s_sel_o, s_sel_o0;
   logic [AW-1:0]   s_adr_o, s_adr_o0;
   logic [DW-1:0]   s_dat_o, s_dat_o0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_slave_port_arbiter #(.NUM_M(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt));

   wb_slave_port_arbiter #(.NUM_M(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o0),
      .m_ack_o(m_ack_o0), .m_err_o(m_err_o0), .s_cyc_o(s_cyc_o0), .s_stb_o(s_stb_o0),
      .s_we_o(s_we_o0), .s_sel_o(s_sel_o0), .s_adr_o(s_adr_o0), .s_dat_o(s_dat_o0),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   // Entered in IDLE with requests presented; serves one single-beat cycle for master e.
   task automatic serve(input int e, input string tag);
      tick();
      chk({tag, "_gnt"}, 64'(gnt), 64'(4'b0001 << e));
      s_ack = 1'b1;
      #1;
      chk({tag, "_ack"}, 64'(m_ack_o), 64'(4'b0001 << e));
      tick();
      s_ack    = 1'b0;
      m_cyc[e] = 1'b0;
      m_stb[e] = 1'b0;
      #1;
      chk({tag, "_scyc_drop"}, 64'(s_cyc_o), 64'd0);
      tick();
      chk({tag, "_idle_gap"}, 64'(gnt), 64'd0);
      m_cyc[e] = 1'b1;
      m_stb[e] = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      m_cyc   = '0;
      m_stb   = '0;
      m_we    = 4'b0101;
      s_dat_i = '0;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      for (int k = 0; k < N; k++) begin
         m_adr[k*AW +: AW]     = 32'hA000_0000 + 32'(k);
         m_dat[k*DW +: DW]     = 32'hD000_0000 + 32'(k);
         m_sel[k*DW/8 +: DW/8] = 4'(k + 1);
      end
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_scyc", 64'(s_cyc_o), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // single request from master 2
      m_cyc = 4'b0100;
      m_stb = 4'b0100;
      #1;
      chk("single_pre_gnt", 64'(gnt), 64'd0);
      tick();
      chk("single_gnt", 64'(gnt), 64'h4);
      chk("single_scyc", 64'(s_cyc_o), 64'd1);
      chk("single_adr", 64'(s_adr_o), 64'hA000_0002);
      chk("single_dat", 64'(s_dat_o), 64'hD000_0002);
      chk("single_sel", 64'(s_sel_o), 64'h3);
      chk("single_we", 64'(s_we_o), 64'd1);
      s_ack   = 1'b1;
      s_dat_i = 32'h1234_5678;
      #1;
      chk("single_ack", 64'(m_ack_o), 64'h4);
      chk("single_rdat", 64'(m_dat_o), 64'h1234_5678);
      chk("single_err", 64'(m_err_o), 64'd0);
      tick();
      s_ack = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      tick();
      chk("single_release", 64'(gnt), 64'd0);
      s_ack = 1'b1;
      #1;
      chk("idle_ack_iso", 64'(m_ack_o), 64'd0);
      chk("idle_rdat", 64'(m_dat_o), 64'd0);
      s_ack = 1'b0;

      // round robin from reset pointer
      pulse_reset();
      m_cyc = 4'b1111;
      m_stb = 4'b1111;
      serve(0, "rr0");
      serve(1, "rr1");
      serve(2, "rr2");
      serve(3, "rr3");
      serve(0, "rr4");

      // wrap between masters 3 and 0
      m_cyc = '0;
      m_stb = '0;
      pulse_reset();
      m_cyc = 4'b1001;
      m_stb = 4'b1001;
      serve(0, "wrap0");
      serve(3, "wrap3");
      serve(0, "wrap0b");

      // watchdog on master 1
      m_cyc = '0;
      m_stb = '0;
      pulse_reset();
      m_cyc = 4'b0010;
      m_stb = 4'b0010;
      tick();
      chk("wd_gnt", 64'(gnt), 64'h2);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("wd_no_err_early", 64'(m_err_o), 64'd0);
         chk("wd_stb_early", 64'(s_stb_o), 64'd1);
      end
      tick();
      chk("wd_fire_err", 64'(m_err_o), 64'h2);
      chk("wd_fire_stb", 64'(s_stb_o), 64'd0);
      chk("wd0_never", 64'(m_err_o0), 64'd0);
      tick();
      chk("wd_clear_err", 64'(m_err_o), 64'd0);
      chk("wd_clear_stb", 64'(s_stb_o), 64'd1);
      for (int c = 0; c < 4; c++) tick();
      chk("wd_refire", 64'(m_err_o), 64'h2);
      chk("wd0_still_never", 64'(m_err_o0), 64'd0);
      s_ack = 1'b1;
      #1;
      chk("ack_beats_wd_err", 64'(m_err_o), 64'd0);
      chk("ack_beats_wd_ack", 64'(m_ack_o), 64'h2);
      chk("ack_beats_wd_stb", 64'(s_stb_o), 64'd1);
      tick();
      s_err = 1'b1;
      #1;
      chk("both_ack", 64'(m_ack_o), 64'h2);
      chk("both_err", 64'(m_err_o), 64'h2);
      tick();
      s_err = 1'b0;
      m_stb = 4'b0000;
      #1;
      chk("stb_low_ack_ignored", 64'(m_ack_o), 64'd0);
      m_stb = 4'b0010;
      #1;
      chk("iso_owner1_ack", 64'(m_ack_o), 64'h2);

      // asynchronous reset mid-transfer
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt", 64'(gnt), 64'd0);
      chk("midrst_scyc", 64'(s_cyc_o), 64'd0);
      chk("midrst_ack", 64'(m_ack_o), 64'd0);
      s_ack = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
